// File: rtl/mem_bus_master_if.sv
// CPU-side request/response handshake of the memory bus master.
// The CPU owns the request fields; the bus master owns ready and response.
interface mem_bus_master_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_we;
   logic [DATA_W-1:0] resp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_we, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, resp_valid, resp_we, resp_rdata
   );
endinterface

// File: rtl/mem_bus_master.sv
// Single-outstanding initiator for the shared-bus 32x8 memory: read 3 cycles, write 2 cycles.
// req_ready only in IDLE; responses are one-cycle strobes with no back-pressure.
module mem_bus_master #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_bus_master_if.slave   bus,
   output logic              mem_write_en,
   output logic [ADDR_W-1:0] mem_address,
   inout  wire  [DATA_W-1:0] mem_data
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DATA, WR} state_t;

   state_t            state;
   logic [DATA_W-1:0] wdata_q;

   assign bus.req_ready = rst_n && (state == IDLE);

   // The memory drives whenever write_en is low, so bus ownership follows the same register.
   assign mem_data = mem_write_en ? wdata_q : {DATA_W{1'bz}};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         mem_write_en   <= 1'b0;
         mem_address    <= '0;
         wdata_q        <= '0;
         bus.resp_valid <= 1'b0;
         bus.resp_we    <= 1'b0;
         bus.resp_rdata <= '0;
      end else begin
         bus.resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid && bus.req_ready) begin
                  mem_address <= bus.req_addr;
                  wdata_q     <= bus.req_wdata;
                  if (bus.req_we) begin
                     mem_write_en <= 1'b1;
                     state        <= WR;
                  end else begin
                     state        <= RD_WAIT;
                  end
               end
            end
            // Memory registers its output at the end of this cycle.
            RD_WAIT: state <= RD_DATA;
            RD_DATA: begin
               bus.resp_rdata <= mem_data;
               bus.resp_valid <= 1'b1;
               bus.resp_we    <= 1'b0;
               state          <= IDLE;
            end
            WR: begin
               mem_write_en   <= 1'b0;
               bus.resp_valid <= 1'b1;
               bus.resp_we    <= 1'b1;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a behavioural shared-bus 32x8 memory.
module tb_mem_bus_master;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              mem_write_en;
   logic [ADDR_W-1:0] mem_address;
   wire  [DATA_W-1:0] mem_data;

   mem_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus.slave),
      .mem_write_en (mem_write_en),
      .mem_address  (mem_address),
      .mem_data     (mem_data)
   );

   always #5 clk = ~clk;

   // Memory model: registered read while write_en low, write on edge while high.
   logic [DATA_W-1:0] mem [0:31];
   logic [DATA_W-1:0] mem_q = '0;

   assign mem_data = mem_write_en ? {DATA_W{1'bz}} : mem_q;

   always @(posedge clk) begin
      if (mem_write_en) mem[mem_address] <= mem_data;
      else              mem_q <= mem[mem_address];
   end

   int total = 0;
   int bad   = 0;
   int conflicts = 0;
   logic [DATA_W-1:0] wr_exp = '0;
   logic [DATA_W-1:0] last_rd = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Bus monitor: the value on mem_data must always be the one owner's value.
   always @(negedge clk) begin
      if (mem_write_en) begin
         if (mem_data !== wr_exp) conflicts++;
      end else begin
         if (mem_data !== mem_q) conflicts++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = a;
      chk("rd_ready_idle", bus.req_ready, 1'b1);
      tick();
      bus.req_valid = 1'b0;
      bus.req_addr  = ~a;
      chk("rd_addr", mem_address, a);
      chk("rd_we0_c1", mem_write_en, 1'b0);
      chk("rd_busy_c1", bus.req_ready, 1'b0);
      chk("rd_nresp_c1", bus.resp_valid, 1'b0);
      tick();
      chk("rd_we0_c2", mem_write_en, 1'b0);
      chk("rd_addr_c2", mem_address, a);
      chk("rd_busy_c2", bus.req_ready, 1'b0);
      chk("rd_nresp_c2", bus.resp_valid, 1'b0);
      tick();
      chk("rd_resp", bus.resp_valid, 1'b1);
      chk("rd_resp_we", bus.resp_we, 1'b0);
      chk("rd_data", bus.resp_rdata, exp);
      chk("rd_ready_back", bus.req_ready, 1'b1);
      last_rd = exp;
      tick();
      chk("rd_resp_1cyc", bus.resp_valid, 1'b0);
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = a;
      bus.req_wdata = d;
      wr_exp        = d;
      chk("wr_ready_idle", bus.req_ready, 1'b1);
      tick();
      bus.req_valid = 1'b0;
      bus.req_wdata = ~d;
      chk("wr_we1", mem_write_en, 1'b1);
      chk("wr_bus", mem_data, d);
      chk("wr_addr", mem_address, a);
      chk("wr_busy", bus.req_ready, 1'b0);
      chk("wr_nresp", bus.resp_valid, 1'b0);
      tick();
      chk("wr_we0", mem_write_en, 1'b0);
      chk("wr_ack", bus.resp_valid, 1'b1);
      chk("wr_ack_we", bus.resp_we, 1'b1);
      chk("wr_rdata_hold", bus.resp_rdata, last_rd);
      chk("wr_commit", mem[a], d);
      chk("wr_ready_back", bus.req_ready, 1'b1);
      tick();
      chk("wr_ack_1cyc", bus.resp_valid, 1'b0);
      bus.req_we = 1'b0;
   endtask

   logic [ADDR_W-1:0] b2b_addr [0:2];
   logic [DATA_W-1:0] b2b_data [0:2];

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = DATA_W'(i * 3);
      mem[18] = 8'hA5;
      mem[0]  = 8'h11;
      mem[31] = 8'hF1;
      mem[16] = 8'h60;
      mem[17] = 8'h77;
      mem[25] = 8'h00;
      b2b_addr[0] = 5'd0;  b2b_data[0] = 8'h11;
      b2b_addr[1] = 5'd31; b2b_data[1] = 8'hF1;
      b2b_addr[2] = 5'd16; b2b_data[2] = 8'h60;

      // Reset held with a pending request.
      rst_n         = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 5'd9;
      bus.req_wdata = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_ready", bus.req_ready, 1'b0);
         chk("rst_we", mem_write_en, 1'b0);
         chk("rst_resp", bus.resp_valid, 1'b0);
      end
      chk("rst_addr", mem_address, 5'd0);
      chk("rst_rdata", bus.resp_rdata, 8'h00);
      chk("rst_resp_we", bus.resp_we, 1'b0);
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      rst_n         = 1'b1;
      #1;
      chk("rel_ready", bus.req_ready, 1'b1);
      tick();
      chk("rel_no_accept", mem_write_en, 1'b0);
      chk("rel_no_resp", bus.resp_valid, 1'b0);
      chk("rel_mem9", mem[9], 8'd27);

      do_read(5'd18, 8'hA5);
      do_write(5'd20, 8'h3C);
      do_read(5'd20, 8'h3C);
      do_write(5'd3, 8'hC3);
      do_read(5'd3, 8'hC3);

      // Back-to-back reads with req_valid held; address changes while busy are ignored.
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = b2b_addr[0];
      for (int i = 0; i < 3; i++) begin
         chk("b2b_ready", bus.req_ready, 1'b1);
         tick();
         bus.req_addr = b2b_addr[(i + 1) % 3];
         chk("b2b_addr", mem_address, b2b_addr[i]);
         chk("b2b_busy", bus.req_ready, 1'b0);
         tick();
         chk("b2b_nresp", bus.resp_valid, 1'b0);
         tick();
         chk("b2b_resp", bus.resp_valid, 1'b1);
         chk("b2b_data", bus.resp_rdata, b2b_data[i]);
         if (i == 2) bus.req_valid = 1'b0;
      end
      last_rd = 8'h60;
      tick();
      chk("b2b_end", bus.resp_valid, 1'b0);

      // Reset during RD_DATA of a read to 17.
      bus.req_valid = 1'b1;
      bus.req_addr  = 5'd17;
      tick();
      bus.req_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      chk("rrd_nresp", bus.resp_valid, 1'b0);
      chk("rrd_rdata", bus.resp_rdata, 8'h00);
      rst_n = 1'b1;
      #1;
      chk("rrd_idle", bus.req_ready, 1'b1);
      tick();
      chk("rrd_nresp2", bus.resp_valid, 1'b0);
      last_rd = 8'h00;
      do_read(5'd17, 8'h77);

      // Reset during WR of 8'hFF to 25.
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 5'd25;
      bus.req_wdata = 8'hFF;
      wr_exp        = 8'hFF;
      tick();
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      chk("rwr_we1", mem_write_en, 1'b1);
      rst_n = 1'b0;
      tick();
      chk("rwr_we0", mem_write_en, 1'b0);
      chk("rwr_noack", bus.resp_valid, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("rwr_noack2", bus.resp_valid, 1'b0);
      last_rd = 8'h00;
      do_read(5'd25, 8'hFF);

      chk("bus_conflict", conflicts, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
